// File: rtl/fifo_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl_if
// Groups the signals between a FIFO consumer and the read-side pointer
// controller.
//   master : the consumer side. Drives rd, wptr_sync, clr_err and observes
//            the controller outputs.
//   slave  : the read controller. Drives rptr, rptr_gray, raddr, fifo_rd,
//            fifo_empty, fifo_aempty, level, underflow.
// Ports (all in the read clock domain):
//   rd          read request from the consumer
//   wptr_sync   Gray-coded write pointer, already synchronised into clk
//   clr_err     clears the sticky underflow flag
//   rptr        binary read pointer (ADDR_W+1 bits)
//   rptr_gray   registered Gray read pointer for the write domain
//   raddr       memory read address (low ADDR_W bits of rptr)
//   fifo_rd     qualified read strobe to the memory
//   fifo_empty  registered empty flag
//   fifo_aempty registered almost-empty flag
//   level       registered occupancy in words
//   underflow   sticky flag: read requested while empty
// -----------------------------------------------------------------------------
interface fifo_read_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              rd;
  logic [ADDR_W:0]   wptr_sync;
  logic              clr_err;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   rptr_gray;
  logic [ADDR_W-1:0] raddr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic              fifo_aempty;
  logic [ADDR_W:0]   level;
  logic              underflow;

  modport master (
    output rd, wptr_sync, clr_err,
    input  rptr, rptr_gray, raddr, fifo_rd, fifo_empty, fifo_aempty,
           level, underflow
  );

  modport slave (
    input  rd, wptr_sync, clr_err,
    output rptr, rptr_gray, raddr, fifo_rd, fifo_empty, fifo_aempty,
           level, underflow
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
// Read-side controller of an asynchronous FIFO. Keeps the binary and Gray
// read pointers, compares the next read pointer against the synchronised
// Gray write pointer to produce registered empty / almost-empty / level,
// and raises a sticky underflow flag when a read is requested while empty.
// Parameters:
//   ADDR_W    FIFO address width; pointers carry one extra wrap bit
//   AEMPTY_TH almost-empty threshold in words
// Ports:
//   clk       single clock, all state updates on its rising edge
//   rst_n     asynchronous active-low reset
//   bus       fifo_read_ctrl_if.slave (see the interface header)
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_read_ctrl_if.slave     bus
);

  localparam int PTR_W = ADDR_W + 1;

  // Threshold folded to pointer width so the comparison is width-matched.
  localparam logic [PTR_W-1:0] AEMPTY_LIM = PTR_W'(AEMPTY_TH);

  // ---------------------------------------------------------------------------
  // Gray helpers
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] rgray_q;
  logic [PTR_W-1:0] level_q;
  logic             empty_q;
  logic             aempty_q;
  logic             underflow_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic             fifo_rd;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] occupancy;
  logic             empty_next;
  logic             aempty_next;
  logic             underflow_evt;

  // A read is only issued against the registered empty flag, so a write
  // arriving this cycle cannot enable a read until the flag has updated.
  assign fifo_rd       = bus.rd & ~empty_q;
  assign underflow_evt = bus.rd &  empty_q;

  always_comb begin
    // Pointer arithmetic is modulo 2^PTR_W; the wrap to zero is intentional.
    rbin_next   = rptr_q + PTR_W'(fifo_rd);
    rgray_next  = bin2gray(rbin_next);
    wbin        = gray2bin(bus.wptr_sync);
    occupancy   = wbin - rbin_next;
    // Empty uses the current wptr_sync, so a read that drains the FIFO in
    // the same cycle the writer advances does not flag a false empty.
    empty_next  = (rgray_next == bus.wptr_sync);
    aempty_next = (occupancy <= AEMPTY_LIM);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset branch is listed in the sensitivity list
  // so reset acts without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q      <= '0;
      rgray_q     <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rptr_q   <= rbin_next;
      rgray_q  <= rgray_next;
      level_q  <= occupancy;
      empty_q  <= empty_next;
      aempty_q <= aempty_next;
      // Set has priority over clear so a concurrent event is never lost.
      if (underflow_evt) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rptr        = rptr_q;
  assign bus.rptr_gray   = rgray_q;
  assign bus.raddr       = rptr_q[ADDR_W-1:0];
  assign bus.fifo_rd     = fifo_rd;
  assign bus.fifo_empty  = empty_q;
  assign bus.fifo_aempty = aempty_q;
  assign bus.level       = level_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
// Directed bench for fifo_read_ctrl with ADDR_W=3 (4-bit pointers) and
// AEMPTY_TH=2. Inputs change 1 time unit after a rising edge and outputs are
// sampled there too, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fifo_read_ctrl_if #(.ADDR_W(3)) bus ();

  fifo_read_ctrl #(
    .ADDR_W    (3),
    .AEMPTY_TH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_rptr"},      32'(bus.rptr),        32'd0);
    check({tag, "_rgray"},     32'(bus.rptr_gray),   32'd0);
    check({tag, "_raddr"},     32'(bus.raddr),       32'd0);
    check({tag, "_level"},     32'(bus.level),       32'd0);
    check({tag, "_empty"},     32'(bus.fifo_empty),  32'd1);
    check({tag, "_aempty"},    32'(bus.fifo_aempty), 32'd1);
    check({tag, "_underflow"}, 32'(bus.underflow),   32'd0);
    check({tag, "_fifo_rd"},   32'(bus.fifo_rd),     32'd0);
  endtask

  int exp_level  [5] = '{4, 3, 2, 1, 0};
  int exp_aempty [5] = '{0, 0, 1, 1, 1};
  int exp_empty  [5] = '{0, 0, 0, 0, 1};

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b1;
    bus.rd        = 1'b0;
    bus.wptr_sync = '0;
    bus.clr_err   = 1'b0;

    // Reset asserted before any clock edge: outputs must settle at once.
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("por");
    tick();
    tick();
    rst_n = 1'b1;

    // Read from an empty FIFO: no strobe, pointer holds, underflow sets.
    bus.rd = 1'b1;
    #1 check("empty_rd_strobe", 32'(bus.fifo_rd), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("uf%0d_underflow", k), 32'(bus.underflow),  32'd1);
      check($sformatf("uf%0d_rptr", k),      32'(bus.rptr),       32'd0);
      check($sformatf("uf%0d_empty", k),     32'(bus.fifo_empty), 32'd1);
      check($sformatf("uf%0d_fifo_rd", k),   32'(bus.fifo_rd),    32'd0);
    end

    // Clear with no read pending.
    bus.rd      = 1'b0;
    bus.clr_err = 1'b1;
    tick();
    check("clr_underflow", 32'(bus.underflow), 32'd0);
    bus.clr_err = 1'b0;

    // Writer jumps to 5 words (Gray 0111).
    bus.wptr_sync = 4'b0111;
    tick();
    check("w5_empty",  32'(bus.fifo_empty),  32'd0);
    check("w5_level",  32'(bus.level),       32'd5);
    check("w5_aempty", 32'(bus.fifo_aempty), 32'd0);
    check("w5_rptr",   32'(bus.rptr),        32'd0);

    // Drain five words.
    bus.rd = 1'b1;
    #1 check("drain_strobe", 32'(bus.fifo_rd), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("drain%0d_rptr", i),   32'(bus.rptr),        32'(i + 1));
      check($sformatf("drain%0d_raddr", i),  32'(bus.raddr),       32'(i + 1));
      check($sformatf("drain%0d_level", i),  32'(bus.level),       32'(exp_level[i]));
      check($sformatf("drain%0d_aempty", i), 32'(bus.fifo_aempty), 32'(exp_aempty[i]));
      check($sformatf("drain%0d_empty", i),  32'(bus.fifo_empty),  32'(exp_empty[i]));
    end
    check("drained_strobe", 32'(bus.fifo_rd),   32'd0);
    check("drained_rgray",  32'(bus.rptr_gray), 32'b0111);
    check("drained_uf",     32'(bus.underflow), 32'd0);
    bus.rd = 1'b0;

    // One word arrives (Gray of 6).
    bus.wptr_sync = 4'b0101;
    tick();
    check("w6_level", 32'(bus.level),      32'd1);
    check("w6_empty", 32'(bus.fifo_empty), 32'd0);

    // Read the last word while the writer advances to 7: stays non-empty.
    bus.rd        = 1'b1;
    bus.wptr_sync = 4'b0100;
    tick();
    check("simul_rptr",  32'(bus.rptr),       32'd6);
    check("simul_level", 32'(bus.level),      32'd1);
    check("simul_empty", 32'(bus.fifo_empty), 32'd0);

    // Plain read empties it.
    tick();
    check("last_rptr",  32'(bus.rptr),       32'd7);
    check("last_level", 32'(bus.level),      32'd0);
    check("last_empty", 32'(bus.fifo_empty), 32'd1);

    // Underflow with rd still high, then clear racing a new event.
    tick();
    check("uf2_set",  32'(bus.underflow), 32'd1);
    check("uf2_rptr", 32'(bus.rptr),      32'd7);
    bus.clr_err = 1'b1;
    tick();
    check("uf2_set_wins", 32'(bus.underflow), 32'd1);
    bus.rd = 1'b0;
    tick();
    check("uf2_cleared", 32'(bus.underflow), 32'd0);
    bus.clr_err = 1'b0;

    // Wrap test: build two words of slack, then stream across 15 -> 0.
    bus.wptr_sync = g(8);
    tick();
    check("wrap_pre1_level", 32'(bus.level), 32'd1);
    bus.wptr_sync = g(9);
    tick();
    check("wrap_pre2_level", 32'(bus.level), 32'd2);
    bus.rd = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      bus.wptr_sync = g(9 + k);
      tick();
      check($sformatf("wrap%0d_rptr", k),  32'(bus.rptr),       32'((7 + k) % 16));
      check($sformatf("wrap%0d_rgray", k), 32'(bus.rptr_gray),  32'(g(7 + k)));
      check($sformatf("wrap%0d_level", k), 32'(bus.level),      32'd2);
      check($sformatf("wrap%0d_empty", k), 32'(bus.fifo_empty), 32'd0);
      if (k == 8) check("wrap_gray_15", 32'(bus.rptr_gray), 32'b1000);
      if (k == 9) check("wrap_gray_0",  32'(bus.rptr_gray), 32'b0000);
    end

    // Drain the remaining two words (writer parked at 3).
    tick();
    check("tail1_rptr",  32'(bus.rptr),  32'd2);
    check("tail1_level", 32'(bus.level), 32'd1);
    tick();
    check("tail2_rptr",  32'(bus.rptr),       32'd3);
    check("tail2_empty", 32'(bus.fifo_empty), 32'd1);

    // Async reset between edges while rd is held high at rptr=3.
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    #2 rst_n = 1'b1;

    // First edge after release evaluates from rptr=0 against wptr=3.
    tick();
    check("post_rst_rptr",      32'(bus.rptr),        32'd0);
    check("post_rst_level",     32'(bus.level),       32'd3);
    check("post_rst_empty",     32'(bus.fifo_empty),  32'd0);
    check("post_rst_aempty",    32'(bus.fifo_aempty), 32'd0);
    check("post_rst_underflow", 32'(bus.underflow),   32'd1);
    bus.rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
